// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard controller: memory freeze, branch redirect/flush, load-use stall
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             branch_taken,
    input  logic [31:0]      branch_address,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             pc_redirect,
    output logic [31:0]      pc_target,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t     cur_state, nxt_state;
    logic [2:0] fcnt, fcnt_nxt;
    logic       freeze, load_use, stall_inc, flush_inc;

    assign state  = cur_state;
    assign freeze = dmem_req && !dmem_ready;
    assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // Priority chain: freeze, then redirect, then flush tail, then load-use.
    always_comb begin
        pc_we       = 1'b1;
        pc_redirect = 1'b0;
        pc_target   = 32'd0;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        nxt_state   = ST_RUN;
        fcnt_nxt    = fcnt;

        if (freeze) begin
            pc_we     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            stall_inc = 1'b1;
            // A freeze inside a flush sequence keeps the sequence alive.
            nxt_state = (cur_state == ST_FLUSH) ? ST_FLUSH : ST_MEM_WAIT;
        end else if (branch_taken) begin
            pc_redirect = 1'b1;
            pc_target   = branch_address;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
            fcnt_nxt    = FLUSH_LOAD;
            nxt_state   = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else if (cur_state == ST_FLUSH) begin
            if_id_flush = 1'b1;
            fcnt_nxt    = fcnt - 3'd1;
            nxt_state   = (fcnt <= 3'd1) ? ST_RUN : ST_FLUSH;
        end else if (load_use) begin
            pc_we       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= ST_RUN;
            fcnt      <= 3'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            cur_state <= nxt_state;
            fcnt      <= fcnt_nxt;
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_ONE;
            if (flush_inc && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 1, legal 1..7; number of cycles the IF/ID register is flushed after a redirect.
REQ-002 Parameter: CNT_W, default 16; width of the performance counters.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 branch_taken  in  1  execute stage reports a mispredicted branch or jump.
REQ-006 branch_address  in  32  correct target from the execute stage.
REQ-007 id_rs1, id_rs2  in  5 each  source registers of the instruction in decode.
REQ-008 id_use_rs1, id_use_rs2  in  1 each  decode instruction reads rs1 / rs2.
REQ-009 ex_rd  in  5  destination of the instruction in execute.
REQ-010 ex_is_load  in  1  execute instruction is a load.
REQ-011 dmem_req, dmem_ready  in  1 each  memory-stage access pending / memory acknowledges it.
REQ-012 pc_we  out  1  PC register update enable.
REQ-013 pc_redirect  out  1  PC takes pc_target instead of sequential/predicted value.
REQ-014 pc_target  out  32  redirect address.
REQ-015 if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline-register enables.
REQ-016 if_id_flush, id_ex_flush  out  1 each  load a bubble (valid=0) into that register.
REQ-017 state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 FLUSH.
REQ-018 stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-019 Default (RUN, no event): all enables 1, both flushes 0, pc_we 1, pc_redirect 0.
REQ-020 Freeze condition: dmem_req=1 and dmem_ready=0; highest priority in every state.
REQ-021 Freeze: all four enables 0, pc_we 0, flushes 0, pc_redirect 0; branch_taken and load-use ignored that cycle; next state MEM_WAIT.
REQ-022 MEM_WAIT: freeze outputs while dmem_ready=0; on dmem_ready=1, that cycle uses RUN outputs and rules, next state RUN (or FLUSH if a redirect fires that cycle).
REQ-023 Redirect: branch_taken=1 and not frozen -> pc_we 1, pc_redirect 1, pc_target=branch_address, if_id_flush 1, id_ex_flush 1, same cycle (zero latency).
REQ-024 After a redirect, if FLUSH_CYCLES>1: state FLUSH, down-counter loaded with FLUSH_CYCLES-1; else stay RUN.
REQ-025 FLUSH: if_id_flush 1, id_ex_flush 0, pc_we 1, counter decrements per unfrozen cycle; at 1 -> RUN next cycle.
REQ-026 Freeze during FLUSH: freeze outputs, counter holds, state stays FLUSH (MEM_WAIT not entered).
REQ-027 Redirect during FLUSH: restarts redirect per REQ-023/024, counter reloaded.
REQ-028 Load-use: ex_is_load=1, ex_rd!=0, and ((id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd)).
REQ-029 Load-use in RUN, no freeze/redirect: pc_we 0, if_id_en 0, id_ex_flush 1, other enables 1; one bubble per cycle condition holds.
REQ-030 Priority: freeze > redirect > load-use; load-use ignored in FLUSH.
REQ-031 pc_target = branch_address when pc_redirect=1, else 0.
REQ-032 stall_cnt +1 each cycle freeze or load-use stall is applied; flush_cnt +1 per redirect; both saturate at all-ones.
REQ-033 All outputs except state/counters are combinational from inputs and registered state.

Reset
REQ-034 reset=0 asynchronously: state RUN, flush counter 0, stall_cnt 0, flush_cnt 0; outputs take RUN values per REQ-019 gated by current inputs.
REQ-035 Reset asserted mid-FLUSH or mid-MEM_WAIT aborts the sequence; first cycle after release is RUN.

Verification
REQ-036 Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_we 0, if_id_en 0, id_ex_flush 1, stall_cnt +1; ex_rd=0 -> no stall.
REQ-037 Redirect, FLUSH_CYCLES=3: branch_taken=1, branch_address=0x0000_0100 -> same cycle pc_redirect 1, pc_target 0x100, both flushes; next 2 cycles state FLUSH, if_id_flush 1; then RUN; flush_cnt=1.
REQ-038 Memory wait: dmem_req=1, dmem_ready=0 for 4 cycles with branch_taken=1 -> all enables 0, no redirect, state MEM_WAIT; dmem_ready=1 -> redirect fires that cycle.
REQ-039 Freeze inside FLUSH (FLUSH_CYCLES=3): 2-cycle freeze after redirect -> counter holds, FLUSH lasts 2 unfrozen cycles total.
REQ-040 Saturation: drive load-use 2^CNT_W+5 cycles -> stall_cnt holds 0xFFFF (CNT_W=16).
REQ-041 Async reset during MEM_WAIT -> state 0 immediately, counters 0, RUN on release.
